// File: rtl/tmds_pkg.sv
// Shared TMDS constants: symbol width, the four control-period symbols and the
// clock-lane pattern used by the serialiser.
package tmds_pkg;

    localparam int TMDS_SYM_W = 10;

    typedef logic [TMDS_SYM_W-1:0] tmds_sym_t;

    // Control symbols indexed by C1C0
    localparam tmds_sym_t TMDS_CTRL_00 = 10'b11010_10100;
    localparam tmds_sym_t TMDS_CTRL_01 = 10'b00101_01011;
    localparam tmds_sym_t TMDS_CTRL_10 = 10'b01010_10100;
    localparam tmds_sym_t TMDS_CTRL_11 = 10'b10101_01011;

    localparam tmds_sym_t TMDS_CLK_PATTERN = 10'b00000_11111;

endpackage

// File: rtl/tmds_shift_lane.sv
// One serial lane: a symbol shifter (parallel load, shift right) followed by a
// registered output bit with optional polarity inversion.
module tmds_shift_lane
    import tmds_pkg::*;
#(
    parameter int   SYM_W  = TMDS_SYM_W,
    parameter logic INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SYM_W-1:0] load_val,
    output logic             ser_out
);

    logic [SYM_W-1:0] shift_q, shift_d;
    logic             ser_q, ser_d;

    always_comb begin
        shift_d = load ? load_val : {1'b0, shift_q[SYM_W-1:1]};
        ser_d   = shift_q[0] ^ INVERT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            ser_q   <= INVERT;
        end else begin
            shift_q <= shift_d;
            ser_q   <= ser_d;
        end
    end

    assign ser_out = ser_q;

endmodule

// File: rtl/tmds_serializer.sv
// Bit-rate TMDS serialiser: one-deep symbol-group buffer with valid/ready input,
// CHANNELS data lanes plus a clock lane, idle-symbol substitution on underrun.
module tmds_serializer
    import tmds_pkg::*;
#(
    parameter int                 CHANNELS    = 3,
    parameter int                 SYM_W       = TMDS_SYM_W,
    parameter logic [CHANNELS:0]  INV_MASK    = '0,
    parameter logic [SYM_W-1:0]   CLK_PATTERN = TMDS_CLK_PATTERN,
    parameter logic [SYM_W-1:0]   IDLE_SYM    = TMDS_CTRL_00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*SYM_W-1:0] sym_in,
    input  logic                      sym_valid,
    output logic                      sym_ready,
    input  logic                      underrun_clr,
    output logic [CHANNELS-1:0]       tmds_ser,
    output logic                      tmds_clk_ser,
    output logic                      sym_load,
    output logic                      underrun
);

    localparam int              CNT_W    = $clog2(SYM_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_W - 1);

    // Handshake: sym_ready is a function of state only (hold_full_q, bit_cnt_q),
    // never of sym_valid; a group transfers on any edge where both are high.
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [CHANNELS*SYM_W-1:0] hold_q, hold_d;
    logic                      hold_full_q, hold_full_d;
    logic                      armed_q, armed_d;
    logic                      underrun_q, underrun_d;
    logic                      load;
    logic                      accept;
    logic [CHANNELS*SYM_W-1:0] lane_load_val;

    assign load   = (bit_cnt_q == CNT_LAST);
    assign accept = sym_valid && sym_ready;

    always_comb begin
        bit_cnt_d     = load ? '0 : bit_cnt_q + CNT_W'(1);
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        armed_d       = armed_q | accept;
        underrun_d    = underrun_q & ~underrun_clr;
        lane_load_val = {CHANNELS{IDLE_SYM}};

        if (load) begin
            if (hold_full_q) begin
                lane_load_val = hold_q;
                hold_full_d   = accept;
                if (accept) begin
                    hold_d = sym_in;
                end
            end else if (accept) begin
                // Bypass: the group goes straight into the shifters
                lane_load_val = sym_in;
                hold_full_d   = 1'b0;
            end else begin
                hold_full_d = 1'b0;
                if (armed_q) begin
                    underrun_d = 1'b1;
                end
            end
        end else if (accept) begin
            hold_d      = sym_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= CNT_LAST;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            armed_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            armed_q     <= armed_d;
            underrun_q  <= underrun_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        tmds_shift_lane #(
            .SYM_W  (SYM_W),
            .INVERT (INV_MASK[i])
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .load_val (lane_load_val[i*SYM_W +: SYM_W]),
            .ser_out  (tmds_ser[i])
        );
    end

    tmds_shift_lane #(
        .SYM_W  (SYM_W),
        .INVERT (INV_MASK[CHANNELS])
    ) u_clk_lane (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (CLK_PATTERN),
        .ser_out  (tmds_clk_ser)
    );

    assign sym_ready = !hold_full_q || load;
    assign sym_load  = load;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_tmds_serializer.sv
// Directed bench for tmds_serializer: idle fill, bypass, streaming, underrun
// set/clear, lane inversion (second instance) and mid-symbol reset.
module tb_tmds_serializer;

    localparam logic [9:0] EXP_IDLE = 10'b11010_10100;
    localparam logic [9:0] EXP_CLK  = 10'b00000_11111;
    localparam logic [29:0] IDLE3 = {EXP_IDLE, EXP_IDLE, EXP_IDLE};
    // Groups packed {lane2, lane1, lane0}
    localparam logic [29:0] G1 = {10'h155, 10'h000, 10'h3FF};
    localparam logic [29:0] G2 = {10'h01F, 10'h3E0, 10'h0AA};
    localparam logic [29:0] G3 = {10'h2CD, 10'h133, 10'h3C3};
    localparam logic [29:0] G4 = {10'h001, 10'h200, 10'h25A};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] sym_in;
    logic        sym_valid;
    logic        underrun_clr;
    logic        sym_ready;
    logic [2:0]  tmds_ser;
    logic        tmds_clk_ser;
    logic        sym_load;
    logic        underrun;

    logic [2:0]  inv_ser;
    logic        inv_clk_ser;
    logic        inv_ready;
    logic        inv_load;
    logic        inv_underrun;

    int checks = 0;
    int errors = 0;
    int edge_n = -1;
    logic [29:0] src_q[$];

    tmds_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .sym_in       (sym_in),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .underrun_clr (underrun_clr),
        .tmds_ser     (tmds_ser),
        .tmds_clk_ser (tmds_clk_ser),
        .sym_load     (sym_load),
        .underrun     (underrun)
    );

    tmds_serializer #(.INV_MASK(4'b1001)) dut_inv (
        .clk          (clk),
        .rst          (rst),
        .sym_in       (30'd0),
        .sym_valid    (1'b1),
        .sym_ready    (inv_ready),
        .underrun_clr (1'b0),
        .tmds_ser     (inv_ser),
        .tmds_clk_ser (inv_clk_ser),
        .sym_load     (inv_load),
        .underrun     (inv_underrun)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [29:0] obs, input logic [29:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: present the head of src_q, garbage data when idle
    task automatic drive();
        if (src_q.size() > 0) begin
            sym_valid = 1'b1;
            sym_in    = src_q[0];
        end else begin
            sym_valid = 1'b0;
            sym_in    = 30'($urandom);
        end
    endtask

    task automatic tick();
        logic acc;
        acc = sym_valid && sym_ready;
        @(posedge clk);
        #1;
        edge_n++;
        if (acc) void'(src_q.pop_front());
        drive();
    endtask

    // Check bits k0..k1 of the symbol now on the lanes, one edge per bit
    task automatic expect_bits(input logic [29:0] lanes, input int k0, input int k1,
                               input string tag, input bit rdy_pulse, input logic exp_ur);
        for (int k = k0; k <= k1; k++) begin
            logic exp_load;
            tick();
            exp_load = ((edge_n + 1) % 10 == 0);
            chk({tag, "_data"}, {27'd0, tmds_ser}, {27'd0, lanes[20+k], lanes[10+k], lanes[k]});
            chk({tag, "_clk"}, {29'd0, tmds_clk_ser}, {29'd0, EXP_CLK[k]});
            chk({tag, "_load"}, {29'd0, sym_load}, {29'd0, exp_load});
            chk({tag, "_ready"}, {29'd0, sym_ready}, {29'd0, rdy_pulse ? exp_load : 1'b1});
            chk({tag, "_underrun"}, {29'd0, underrun}, {29'd0, exp_ur});
            chk({tag, "_inv_data"}, {27'd0, inv_ser}, 30'b001);
            chk({tag, "_inv_clk"}, {29'd0, inv_clk_ser}, {29'd0, ~EXP_CLK[k]});
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ser"}, {27'd0, tmds_ser}, 30'd0);
        chk({tag, "_clk"}, {29'd0, tmds_clk_ser}, 30'd0);
        chk({tag, "_ready"}, {29'd0, sym_ready}, 30'd1);
        chk({tag, "_load"}, {29'd0, sym_load}, 30'd1);
        chk({tag, "_underrun"}, {29'd0, underrun}, 30'd0);
        chk({tag, "_inv_ser"}, {27'd0, inv_ser}, 30'b001);
        chk({tag, "_inv_clk"}, {29'd0, inv_clk_ser}, 30'd1);
    endtask

    initial begin
        underrun_clr = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        edge_n = -1;
        tick();
        chk("first_load_ser", {27'd0, tmds_ser}, 30'd0);

        // Idle fill with no data, not armed
        expect_bits(IDLE3, 0, 9, "idle_p0", 1'b0, 1'b0);
        expect_bits(IDLE3, 0, 9, "idle_p1", 1'b0, 1'b0);
        expect_bits(IDLE3, 0, 8, "idle_p2", 1'b0, 1'b0);
        src_q.push_back(G1);
        src_q.push_back(G2);
        src_q.push_back(G3);
        src_q.push_back(G4);
        drive();
        // G1 accepted on the load edge by bypass; hold stays empty so ready stays 1
        expect_bits(IDLE3, 9, 9, "bypass_edge", 1'b0, 1'b0);

        // Streaming: ready pulses only in the load cycle while the buffer is full
        expect_bits(G1, 0, 9, "g1", 1'b1, 1'b0);
        expect_bits(G2, 0, 9, "g2", 1'b1, 1'b0);
        expect_bits(G3, 0, 8, "g3", 1'b1, 1'b0);
        expect_bits(G3, 9, 9, "g3_drain", 1'b0, 1'b0);
        expect_bits(G4, 0, 8, "g4", 1'b0, 1'b0);
        expect_bits(G4, 9, 9, "g4_sub_edge", 1'b0, 1'b1);

        // Underrun idle period: clear, then clear colliding with a new set
        expect_bits(IDLE3, 0, 3, "ur_idle", 1'b0, 1'b1);
        underrun_clr = 1'b1;
        expect_bits(IDLE3, 4, 4, "ur_clear", 1'b0, 1'b0);
        underrun_clr = 1'b0;
        expect_bits(IDLE3, 5, 8, "ur_cleared", 1'b0, 1'b0);
        underrun_clr = 1'b1;
        expect_bits(IDLE3, 9, 9, "ur_set_wins", 1'b0, 1'b1);
        underrun_clr = 1'b0;
        expect_bits(IDLE3, 0, 4, "ur_idle2", 1'b0, 1'b1);

        // Asynchronous reset while bit 4 is on the output
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        edge_n = -1;
        tick();
        chk("rst2_first_load_ser", {27'd0, tmds_ser}, 30'd0);
        expect_bits(IDLE3, 0, 9, "rst_idle_p0", 1'b0, 1'b0);
        expect_bits(IDLE3, 0, 9, "rst_idle_p1", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmds_serializer.md
# tmds_serializer

Parametrised single-clock TMDS serialiser. It takes parallel TMDS symbols for N data channels, with a valid/ready handshake, and shifts them out LSB-first at bit rate. Alongside the data it generates the TMDS clock channel and applies per-lane polarity inversion. It sits between the TMDS encoders and the per-lane differential output buffers, which the parent instantiates. When upstream underruns it substitutes a control symbol so the link never stalls.

## Interface
Parameters:
- CHANNELS, 3: number of data lanes.
- SYM_W, 10: symbol width in bits; must be ≥ 2.
- INV_MASK, 0: CHANNELS+1 bits. Bit i inverts data lane i; bit CHANNELS inverts the clock lane (board pin-swap fix).
- CLK_PATTERN, 10'b00000_11111: clock-lane symbol, repeated every symbol period.
- IDLE_SYM, 10'b11010_10100: symbol sent on underrun (control period, C1C0=00).

Ports:
- clk  in  1: bit-rate clock (SYM_W × pixel rate).
- rst  in  1: asynchronous, active-high reset.
- sym_in  in  CHANNELS*SYM_W: lane i occupies bits [i*SYM_W +: SYM_W].
- sym_valid  in  1: sym_in holds a symbol group.
- sym_ready  out  1: serialiser accepts the group this cycle.
- underrun_clr  in  1: clears underrun.
- tmds_ser  out  CHANNELS: serial data bits, registered.
- tmds_clk_ser  out  1: serial clock-lane bit, registered.
- sym_load  out  1: high in the cycle whose closing edge loads the shifters.
- underrun  out  1: sticky; an IDLE_SYM was substituted after the block was armed.

## Operation
- bit_cnt runs 0..SYM_W-1 and wraps. load = (bit_cnt == SYM_W-1); sym_load = load.
- One holding register with flag hold_full stores a whole symbol group.
- sym_ready = !hold_full || load. It depends on state only, never on sym_valid.
- Accept = sym_valid && sym_ready. The first accept after reset sets `armed`.
- Load edge, per lane, from the holding register state:
  - hold_full: shifter ← holding.
  - Empty with accept this cycle: shifter ← sym_in (bypass).
  - Otherwise: shifter ← IDLE_SYM. If armed, set underrun.
- Load edge, holding register:
  - hold_full ← 1 if accept this cycle, else 0.
  - holding ← sym_in on accept, unless the accepted group went straight to the shifter by bypass; in that case hold_full ← 0.
- Non-load edges:
  - Each shifter shifts right by one.
  - An accept loads the holding register and sets hold_full.
- The clock-lane shifter reloads CLK_PATTERN at every load edge and shifts in lockstep with the data lanes.
- Output register: tmds_ser[i] ← shifter_i[0] ^ INV_MASK[i]; tmds_clk_ser ← clk_shifter[0] ^ INV_MASK[CHANNELS].
- underrun is cleared by underrun_clr. If a set and a clear land on the same edge, the set wins.

## Timing
- Reset values:
  - bit_cnt = SYM_W-1, so the first edge after release is a load edge.
  - Shifters = 0, hold_full = 0, armed = 0, underrun = 0.
  - tmds_ser = INV_MASK[CHANNELS-1:0], tmds_clk_ser = INV_MASK[CHANNELS].
  - sym_ready = 1, sym_load = 1.
- Latency, with load edge E: bit k of the loaded symbol is on the output from edge E+1+k, k = 0..SYM_W-1. Symbols are gapless and back-to-back.
- Accepted at the load edge by bypass: first bit appears one edge later.
- Accepted on a non-load edge: output starts one edge after the next load edge.
- Throughput: one group per SYM_W cycles. At most one group is buffered beyond the one shifting.
- Reset mid-symbol: everything clears immediately and the partial symbol is lost. After release, the first load emits IDLE_SYM without setting underrun, because armed is 0.
- Clock lane: CLK_PATTERN bit 0 is aligned with data bit 0 on every symbol.

## Structure
- Package tmds_pkg holds:
  - TMDS_SYM_W = 10.
  - Control symbols TMDS_CTRL_00/01/10/11.
  - TMDS_CLK_PATTERN.
  - A tmds_sym_t typedef (logic [9:0]).
- Parameter defaults reference the package.
- Sub-module tmds_shift_lane: one SYM_W shifter with load, shift and output inversion register. It is instantiated CHANNELS+1 times; the clock lane uses a constant load value.
- The top level owns bit_cnt, the holding register, the handshake and the underrun/armed logic.
- Differential output buffers stay outside this block.

## Test plan
1. Reset, then sym_valid held low for 30 cycles:
   - All lanes repeat IDLE_SYM LSB-first (0,0,1,0,1,0,1,0,1,1) with no gaps.
   - Clock lane repeats 1,1,1,1,1,0,0,0,0,0.
   - underrun stays 0.
2. Continuous valid with lane groups {10'h3FF, 10'h000, 10'h155}, then {10'h0AA, …}:
   - Lane 0 shows ten 1s, lane 1 ten 0s, lane 2 alternating 1,0 starting with 1.
   - Next symbol follows immediately.
   - sym_ready pulses once per 10 cycles, aligned with sym_load.
3. Accept one group on the load cycle with hold empty (bypass):
   - First bit appears on the following edge.
   - Holding stays empty.
4. Stop sym_valid after the first accept:
   - Next symbol period is IDLE_SYM; underrun = 1 from that load edge.
   - underrun_clr clears it; underrun_clr asserted on a substitution edge leaves it at 1.
5. INV_MASK = 4'b1001, all-zero data:
   - Lane 0 constant 1, lanes 1–2 constant 0.
   - Clock lane shows the inverted pattern 0,0,0,0,0,1,1,1,1,1.
6. Assert rst at bit 4 of a symbol:
   - Outputs take reset values asynchronously.
   - After release, the first symbol is IDLE_SYM and underrun stays 0.
